// File: rtl/arbiter_rr4_8bits_pkg.sv
// Shared types for the lane demux / lane FIFO / round-robin drain path.
// No logic here: state encoding and lane-count constants only.
package arbiter_rr4_8bits_pkg;

    localparam int NUM_LANES = 4;
    localparam int BW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arbiter_rr4_8bits_rr_pick4.sv
// Combinational 4-way round-robin picker: first eligible lane at start, start+1, ...
// Zero latency; no backpressure (pure function of its inputs).
module rr_pick4 (
    input  logic [3:0] eligible,
    input  logic [1:0] start,
    output logic [1:0] sel,
    output logic       any
);

    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;

    // rot[j] is eligibility of lane (start + j) mod 4
    assign dbl = {eligible, eligible} >> start;
    assign rot = dbl[3:0];

    always_comb begin
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign sel = start + off;
    assign any = |eligible;

endmodule

// File: rtl/arbiter_rr4_8bits.sv
// Round-robin drain of four show-ahead lane FIFOs onto one byte stream, bounded bursts per grant.
// Pop is combinational, data_out/valid_out follow one cycle later; out_afull stalls all pops.
module arbiter_rr4_8bits
    import arbiter_rr4_8bits_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int BURST = 2
) (
    input  logic                 clk_f,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] fifo_empty,
    input  logic [BW-1:0]        fifo_data0,
    input  logic [BW-1:0]        fifo_data1,
    input  logic [BW-1:0]        fifo_data2,
    input  logic [BW-1:0]        fifo_data3,
    input  logic [NUM_LANES-1:0] lane_en,
    input  logic                 out_afull,
    output logic [NUM_LANES-1:0] pop,
    output logic [BW-1:0]        data_out,
    output logic                 valid_out,
    output logic [1:0]           grant_idx,
    output logic                 busy
);

    localparam logic [3:0] BURST_L = 4'(BURST);

    arb_state_t           state, state_nxt;
    logic [1:0]           last, last_nxt;
    logic [1:0]           grant_nxt;
    logic [3:0]           burst_cnt, cnt_nxt;
    logic [NUM_LANES-1:0] eligible;
    logic [NUM_LANES-1:0] pop_raw;
    logic [1:0]           pick_start;
    logic [1:0]           pick_sel;
    logic                 pick_any;
    logic [BW-1:0]        pop_dat;

    assign eligible = lane_en & ~fifo_empty;

    // In SERVE the search always restarts just after the current holder,
    // so a burst-exhausted lane is only re-granted when it is the sole candidate.
    assign pick_start = (state == SERVE) ? grant_idx + 2'd1 : last + 2'd1;

    rr_pick4 u_pick (
        .eligible (eligible),
        .start    (pick_start),
        .sel      (pick_sel),
        .any      (pick_any)
    );

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        grant_nxt = grant_idx;
        cnt_nxt   = burst_cnt;
        pop_raw   = '0;
        case (state)
            IDLE: begin
                if (pick_any && !out_afull) begin
                    pop_raw[pick_sel] = 1'b1;
                    grant_nxt         = pick_sel;
                    cnt_nxt           = 4'd1;
                    state_nxt         = SERVE;
                end
            end
            SERVE: begin
                if (out_afull) begin
                    state_nxt = HOLD;
                end else if (eligible[grant_idx] && (burst_cnt < BURST_L)) begin
                    pop_raw[grant_idx] = 1'b1;
                    cnt_nxt            = burst_cnt + 4'd1;
                end else begin
                    last_nxt = grant_idx;
                    if (pick_any) begin
                        pop_raw[pick_sel] = 1'b1;
                        grant_nxt         = pick_sel;
                        cnt_nxt           = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!out_afull) state_nxt = SERVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset gates pop directly so no lane is drained while the block is held in reset.
    assign pop = pop_raw & {NUM_LANES{~reset}};

    always_comb begin
        pop_dat = fifo_data0;
        if (pop_raw[1])      pop_dat = fifo_data1;
        else if (pop_raw[2]) pop_dat = fifo_data2;
        else if (pop_raw[3]) pop_dat = fifo_data3;
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 2'd3;
            grant_idx <= 2'd0;
            burst_cnt <= 4'd0;
            data_out  <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            grant_idx <= grant_nxt;
            burst_cnt <= cnt_nxt;
            valid_out <= |pop_raw;
            busy      <= (state_nxt == SERVE);
            if (|pop_raw) data_out <= pop_dat;
        end
    end

endmodule

// File: tb/tb_arbiter_rr4_8bits.sv
// Bench for arbiter_rr4_8bits: queue-backed lane FIFO models and an output scoreboard.
// Expected bytes are queued as stimulus is loaded and popped as valid_out appears.
module tb_arbiter_rr4_8bits;

    logic       clk_f = 1'b0;
    logic       reset;
    logic [3:0] fifo_empty;
    logic [7:0] fifo_data0, fifo_data1, fifo_data2, fifo_data3;
    logic [3:0] lane_en;
    logic       out_afull;
    logic [3:0] pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] grant_idx;
    logic       busy;

    always #5 clk_f = ~clk_f;

    arbiter_rr4_8bits #(.BW(8), .BURST(2)) dut (
        .clk_f      (clk_f),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data0 (fifo_data0),
        .fifo_data1 (fifo_data1),
        .fifo_data2 (fifo_data2),
        .fifo_data3 (fifo_data3),
        .lane_en    (lane_en),
        .out_afull  (out_afull),
        .pop        (pop),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .grant_idx  (grant_idx),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$], q1[$], q2[$], q3[$];
    logic [7:0] exp_q[$];
    logic [1:0] grant_log[$];
    logic [3:0] pop_smp, pop_seen;
    int viol, cyc_n, vld_n, first_cyc, last_cyc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
        fifo_data0 = (q0.size() != 0) ? q0[0] : 8'h00;
        fifo_data1 = (q1.size() != 0) ? q1[0] : 8'h00;
        fifo_data2 = (q2.size() != 0) ? q2[0] : 8'h00;
        fifo_data3 = (q3.size() != 0) ? q3[0] : 8'h00;
    endtask

    task automatic load(input int lane, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            case (lane)
                0: q0.push_back(base + 8'(k));
                1: q1.push_back(base + 8'(k));
                2: q2.push_back(base + 8'(k));
                default: q3.push_back(base + 8'(k));
            endcase
        end
        refresh();
    endtask

    task automatic expect_bytes(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(base + 8'(k));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_f);
        #1;
    endtask

    task automatic start_test();
        reset     = 1'b1;
        out_afull = 1'b0;
        lane_en   = 4'hF;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        refresh();
        exp_q.delete();
        grant_log.delete();
        cyc(2);
        reset     = 1'b0;
        vld_n     = 0;
        viol      = 0;
        pop_seen  = 4'h0;
        first_cyc = 0;
        last_cyc  = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        do begin
            cyc(1);
            n++;
        end while ((exp_q.size() != 0 || busy !== 1'b0) && n < 300);
        chk({tag, "_done"}, 32'(n < 300), 32'd1);
        cyc(2);
        chk({tag, "_pop_legal"}, viol, 0);
        chk({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        lane_en   = 4'hF;
        out_afull = 1'b0;
        pop_smp   = 4'h0;
        pop_seen  = 4'h0;
        viol = 0; cyc_n = 0; vld_n = 0; first_cyc = 0; last_cyc = 0;
        refresh();
        #1 reset = 1'b1;

        fork
            forever begin
                @(posedge clk_f);
                #1;
                cyc_n++;
                if (pop_smp[0] && q0.size() != 0) q0.delete(0);
                if (pop_smp[1] && q1.size() != 0) q1.delete(0);
                if (pop_smp[2] && q2.size() != 0) q2.delete(0);
                if (pop_smp[3] && q3.size() != 0) q3.delete(0);
                refresh();
            end
            forever begin
                @(negedge clk_f);
                pop_smp  = pop;
                pop_seen = pop_seen | pop;
                if ((pop & ~(lane_en & ~fifo_empty)) != 4'h0 || $countones(pop) > 1) viol++;
                if (valid_out === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_byte", {24'h0, data_out}, 32'h100);
                    end else begin
                        chk("data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
                        grant_log.push_back(grant_idx);
                        vld_n++;
                        if (vld_n == 1) first_cyc = cyc_n;
                        last_cyc = cyc_n;
                    end
                end
            end
        join_none

        // reset values
        #6;
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_grant", grant_idx, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pop", pop, 4'h0);
        cyc(1);

        // four lanes, two bytes each, full enable
        start_test();
        load(0, 8'h10, 2); load(1, 8'h20, 2); load(2, 8'h30, 2); load(3, 8'h40, 2);
        expect_bytes(8'h10, 2); expect_bytes(8'h20, 2);
        expect_bytes(8'h30, 2); expect_bytes(8'h40, 2);
        drain("t1");
        chk("t1_count", vld_n, 8);
        chk("t1_span", last_cyc - first_cyc + 1, 8);
        chk("t1_empty", fifo_empty, 4'hF);

        // single lane regranted across bursts
        start_test();
        load(2, 8'h50, 5);
        expect_bytes(8'h50, 5);
        drain("t2");
        chk("t2_count", vld_n, 5);
        chk("t2_span", last_cyc - first_cyc + 1, 5);
        chk("t2_lanes", pop_seen, 4'b0100);

        // almost-full mid-burst on lane 1
        start_test();
        load(1, 8'h60, 4);
        expect_bytes(8'h60, 4);
        cyc(1);
        out_afull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_f);
            chk("t3_pop_afull", pop, 4'h0);
            chk("t3_grant_hold", grant_idx, 2'd1);
            cyc(1);
        end
        out_afull = 1'b0;
        drain("t3");
        chk("t3_count", vld_n, 4);
        chk("t3_span", last_cyc - first_cyc + 1, 8);

        // lanes 1 and 3 enabled only
        start_test();
        lane_en = 4'b1010;
        load(0, 8'h70, 4); load(1, 8'h80, 4); load(2, 8'h90, 4); load(3, 8'hA0, 4);
        expect_bytes(8'h80, 2); expect_bytes(8'hA0, 2);
        expect_bytes(8'h82, 2); expect_bytes(8'hA2, 2);
        drain("t4");
        chk("t4_masked", pop_seen & 4'b0101, 4'h0);
        chk("t4_span", last_cyc - first_cyc + 1, 8);
        chk("t4_left", fifo_empty, 4'b1010);

        // asynchronous reset in the middle of a burst
        start_test();
        load(1, 8'hB0, 3);
        cyc(1);
        chk("t5_busy_pre", busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_data", data_out, 8'h00);
        chk("t5_rst_valid", valid_out, 1'b0);
        chk("t5_rst_pop", pop, 4'h0);
        chk("t5_rst_busy", busy, 1'b0);
        load(0, 8'hC0, 2);
        expect_bytes(8'hC0, 2); expect_bytes(8'hB1, 2);
        cyc(2);
        reset = 1'b0;
        drain("t5");
        chk("t5_first_grant", grant_log.size() != 0 ? grant_log[0] : 2'd3, 2'd0);
        chk("t5_count", vld_n, 4);

        // lane 3 empties as out_afull rises
        start_test();
        load(3, 8'hE0, 3);
        expect_bytes(8'hE0, 3);
        cyc(3);
        out_afull = 1'b1;
        load(0, 8'hF0, 2);
        expect_bytes(8'hF0, 2);
        @(negedge clk_f);
        chk("t6_pop_afull", pop, 4'h0);
        chk("t6_lane3_empty", fifo_empty[3], 1'b1);
        cyc(1);
        out_afull = 1'b0;
        @(negedge clk_f);
        chk("t6_pop_hold_exit", pop, 4'h0);
        drain("t6");
        chk("t6_count", vld_n, 5);
        chk("t6_new_grant", grant_log.size() > 3 ? grant_log[3] : 2'd3, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
